// File: rtl/hls_deadlock_monitor_param_pkg.sv
// Shared types and helpers for the parametrised HLS dataflow deadlock monitor.
package hls_dlm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LATCHED = 2'd2
    } dlm_state_e;

    localparam int unsigned MAP_MAX_W  = 1024;
    localparam int unsigned AXIS_MAX_W = 256;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int unsigned axis_width(input int unsigned num_axis);
        return (num_axis > 1) ? $clog2(num_axis) : 1;
    endfunction

    // Owning-process field k of a packed channel map.
    function automatic int unsigned map_field(input logic [MAP_MAX_W-1:0] map,
                                              input int unsigned          k,
                                              input int unsigned          idx_w);
        logic [MAP_MAX_W-1:0] sh;
        logic [MAP_MAX_W-1:0] mask;
        sh   = map >> (k * idx_w);
        mask = (MAP_MAX_W'(1) << idx_w) - MAP_MAX_W'(1);
        return 32'(sh & mask);
    endfunction

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic int unsigned lowest_set(input logic [AXIS_MAX_W-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = int'(AXIS_MAX_W) - 1; i >= 0; i--) begin
            if (v[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hls_deadlock_monitor_param_if.sv
// Monitor-side bundle: control, per-process/per-channel status flags and diagnostics.
interface hls_deadlock_monitor_param_if
    import hls_dlm_pkg::*;
#(
    parameter int unsigned NUM_PROC = 53,
    parameter int unsigned NUM_AXIS = 10,
    parameter int unsigned CNT_W    = 32
);
    localparam int unsigned FA_W = axis_width(NUM_AXIS);

    logic                enable;
    logic                clear;
    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_PROC-1:0] inst_idle_sigs;
    logic [NUM_PROC-1:0] inst_block_sigs;
    logic                block;
    logic                deadlock;
    logic                deadlock_pulse;
    logic [FA_W-1:0]     first_axis_idx;
    logic [NUM_PROC-1:0] blocked_snapshot;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        input  block, deadlock, deadlock_pulse, first_axis_idx, blocked_snapshot, stall_count
    );

    modport slave (
        input  enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        output block, deadlock, deadlock_pulse, first_axis_idx, blocked_snapshot, stall_count
    );

endinterface

// File: rtl/hls_deadlock_monitor_param_reduce.sv
// Combinational reduction: folds AXIS block flags onto owning processes and
// reduces the per-process stop vector; also finds the lowest mapped blocked channel.
module hls_dlm_reduce
    import hls_dlm_pkg::*;
#(
    parameter int unsigned                NUM_PROC = 53,
    parameter int unsigned                NUM_AXIS = 10,
    parameter int unsigned                IDX_W    = 6,
    parameter logic [NUM_AXIS*IDX_W-1:0]  AXIS_MAP = '0,
    localparam int unsigned               FA_W     = axis_width(NUM_AXIS)
) (
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_PROC-1:0] inst_idle_sigs,
    input  logic [NUM_PROC-1:0] inst_block_sigs,
    output logic                has_axis_c,
    output logic                all_stop_c,
    output logic [FA_W-1:0]     first_axis_idx_c
);

    logic [NUM_AXIS-1:0] valid_ch;
    logic [NUM_PROC-1:0] owner_oh [NUM_AXIS];
    logic [NUM_PROC-1:0] proc_axis;
    logic [NUM_PROC-1:0] stop;

    // Channels mapped outside the process range own nothing and never report.
    for (genvar k = 0; k < NUM_AXIS; k++) begin : g_ch
        localparam int unsigned FIELD = map_field(MAP_MAX_W'(AXIS_MAP), k, IDX_W);
        assign valid_ch[k] = (FIELD < NUM_PROC);
        assign owner_oh[k] = (FIELD < NUM_PROC) ? (NUM_PROC'(1) << FIELD) : '0;
    end

    always_comb begin
        proc_axis = '0;
        for (int k = 0; k < NUM_AXIS; k++) begin
            if (axis_block_sigs[k]) proc_axis = proc_axis | owner_oh[k];
        end
    end

    assign stop             = inst_idle_sigs | inst_block_sigs | proc_axis;
    assign has_axis_c       = |proc_axis;
    assign all_stop_c       = &stop;
    assign first_axis_idx_c = FA_W'(lowest_set(AXIS_MAX_W'(axis_block_sigs & valid_ch)));

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Dataflow deadlock monitor: debounced sticky deadlock flag with entry pulse,
// saturating stall counter and a diagnostic snapshot captured at latch time.
module hls_deadlock_monitor_param
    import hls_dlm_pkg::*;
#(
    parameter int unsigned               NUM_PROC    = 53,
    parameter int unsigned               NUM_AXIS    = 10,
    parameter int unsigned               IDX_W       = 6,
    parameter logic [NUM_AXIS*IDX_W-1:0] AXIS_MAP    = '0,
    parameter int unsigned               HOLD_CYCLES = 16,
    parameter int unsigned               CNT_W       = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
    hls_deadlock_monitor_param_if.slave  mon
);

    localparam int unsigned     FA_W     = axis_width(NUM_AXIS);
    localparam int unsigned     HC_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(HOLD_CYCLES - 1);
    localparam logic            ONE_SHOT = (HOLD_CYCLES == 1);

    dlm_state_e          state_q, state_d;
    logic [HC_W-1:0]     hc_q, hc_d;
    logic                block_q, block_d;
    logic                dl_q, dl_d;
    logic                pulse_q, pulse_d;
    logic [FA_W-1:0]     fidx_q, fidx_d;
    logic [NUM_PROC-1:0] snap_q, snap_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                has_axis_c;
    logic                all_stop_c;
    logic                cond_c;
    logic                enter_c;
    logic [FA_W-1:0]     first_axis_idx_c;

    hls_dlm_reduce #(
        .NUM_PROC (NUM_PROC),
        .NUM_AXIS (NUM_AXIS),
        .IDX_W    (IDX_W),
        .AXIS_MAP (AXIS_MAP)
    ) u_reduce (
        .axis_block_sigs  (mon.axis_block_sigs),
        .inst_idle_sigs   (mon.inst_idle_sigs),
        .inst_block_sigs  (mon.inst_block_sigs),
        .has_axis_c       (has_axis_c),
        .all_stop_c       (all_stop_c),
        .first_axis_idx_c (first_axis_idx_c)
    );

    assign cond_c = mon.enable & has_axis_c & all_stop_c;

    // Next-state and capture logic; clear overrides everything, including a live cond.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        block_d = cond_c;
        dl_d    = dl_q;
        pulse_d = 1'b0;
        fidx_d  = fidx_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        enter_c = 1'b0;

        if (cond_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (cond_c) begin
                    if (ONE_SHOT) begin
                        enter_c = 1'b1;
                    end else begin
                        state_d = ARMED;
                        hc_d    = HC_W'(1);
                    end
                end
            end
            ARMED: begin
                if (!cond_c) begin
                    state_d = IDLE;
                    hc_d    = '0;
                end else if (hc_q == HC_LAST) begin
                    enter_c = 1'b1;
                end else begin
                    hc_d = hc_q + HC_W'(1);
                end
            end
            LATCHED: begin
                state_d = LATCHED;
            end
            default: begin
                state_d = IDLE;
                hc_d    = '0;
            end
        endcase

        if (enter_c) begin
            state_d = LATCHED;
            hc_d    = '0;
            dl_d    = 1'b1;
            pulse_d = 1'b1;
            fidx_d  = first_axis_idx_c;
            snap_d  = mon.inst_block_sigs;
        end

        if (mon.clear) begin
            state_d = IDLE;
            hc_d    = '0;
            block_d = 1'b0;
            dl_d    = 1'b0;
            pulse_d = 1'b0;
            fidx_d  = '0;
            snap_d  = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hc_q    <= '0;
            block_q <= 1'b0;
            dl_q    <= 1'b0;
            pulse_q <= 1'b0;
            fidx_q  <= '0;
            snap_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            block_q <= block_d;
            dl_q    <= dl_d;
            pulse_q <= pulse_d;
            fidx_q  <= fidx_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mon.block            = block_q;
    assign mon.deadlock         = dl_q;
    assign mon.deadlock_pulse   = pulse_q;
    assign mon.first_axis_idx   = fidx_q;
    assign mon.blocked_snapshot = snap_q;
    assign mon.stall_count      = cnt_q;

endmodule
